// File: rtl/mux_arbiter_pkg.sv
// Shared types and default sizes for the two-source mux arbiter.
package mux_arbiter_pkg;

    // Identifies which requester owns the shared mux / output word.
    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_t;

    localparam int DATA_W_DEF = 8;
    localparam int CNT_W_DEF  = 16;

endpackage : mux_arbiter_pkg

// File: rtl/day1.sv
// Plain 2:1 multiplexer used as the shared datapath of the arbiter.
module day1 #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              sel_i,
    output logic [DATA_W-1:0] y_o
);

    // sel_i = 0 passes a_i, sel_i = 1 passes b_i
    always_comb begin
        y_o = sel_i ? b_i : a_i;
    end

endmodule : day1

// File: rtl/mux_arbiter.sv
// Two-requester valid/ready arbiter in front of the shared day1 mux.
// The winner steers the mux; the mux output is captured into a one-deep
// output register that can be popped and reloaded in the same cycle.
// Optional feature macro: MUX_ARBITER_RR_EN (round-robin on ties);
// without it a tie always goes to source A.
//
// Handshake semantics: a word moves across an interface on a rising edge
// where that interface's valid and ready are both high. Sources hold
// valid/data stable until ready. Readies depend combinationally on the
// valids and on y_ready_i, never the other way round.
module mux_arbiter
    import mux_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              a_valid_i,
    input  logic [DATA_W-1:0] a_data_i,
    output logic              a_ready_o,
    input  logic              b_valid_i,
    input  logic [DATA_W-1:0] b_data_i,
    output logic              b_ready_o,
    output logic              y_valid_o,
    output logic [DATA_W-1:0] y_data_o,
    output logic              y_src_o,
    input  logic              y_ready_i,
    output logic              sel_o,
    output logic [CNT_W-1:0]  a_cnt_o,
    output logic [CNT_W-1:0]  b_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    src_t              winner;
    src_t              last;
    logic              can_load;
    logic              a_xfer;
    logic              b_xfer;
    logic              xfer;
    logic [DATA_W-1:0] mux_y;

    // The output register can take a word when empty or being popped now
    assign can_load = ~y_valid_o | y_ready_i;

    // Pick the requester; with no requests the select idles on the last grant
    always_comb begin
        winner = last;
        if (a_valid_i && b_valid_i) begin
`ifdef MUX_ARBITER_RR_EN
            winner = (last == SRC_A) ? SRC_B : SRC_A;
`else
            winner = SRC_A;
`endif
        end else if (a_valid_i) begin
            winner = SRC_A;
        end else if (b_valid_i) begin
            winner = SRC_B;
        end
    end

    assign sel_o     = (winner == SRC_B);
    assign a_ready_o = can_load & (winner == SRC_A) & a_valid_i;
    assign b_ready_o = can_load & (winner == SRC_B) & b_valid_i;
    assign a_xfer    = a_ready_o;
    assign b_xfer    = b_ready_o;
    assign xfer      = a_xfer | b_xfer;

    day1 #(
        .DATA_W (DATA_W)
    ) u_mux (
        .a_i   (a_data_i),
        .b_i   (b_data_i),
        .sel_i (sel_o),
        .y_o   (mux_y)
    );

    // Output register: load on a transfer, otherwise empty on a sink pop
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            y_valid_o <= 1'b0;
            y_data_o  <= '0;
            y_src_o   <= 1'b0;
        end else if (xfer) begin
            y_valid_o <= 1'b1;
            y_data_o  <= mux_y;
            y_src_o   <= (winner == SRC_B);
        end else if (y_ready_i) begin
            y_valid_o <= 1'b0;
        end
    end

    // Last-grant pointer; starts at B so that A wins the first tie
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last <= SRC_B;
        end else if (xfer) begin
            last <= winner;
        end
    end

    // Per-source transfer counters, wrapping naturally at all-ones
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_cnt_o <= '0;
            b_cnt_o <= '0;
        end else begin
            if (a_xfer) a_cnt_o <= a_cnt_o + CNT_ONE;
            if (b_xfer) b_cnt_o <= b_cnt_o + CNT_ONE;
        end
    end

endmodule : mux_arbiter

// File: tb/tb_mux_arbiter.sv
// Self-checking bench for mux_arbiter (CNT_W = 4 so counter wrap is cheap).
// Build with +define+MUX_ARBITER_RR_EN to check the round-robin variant.
module tb_mux_arbiter;

    localparam int DW  = 8;
    localparam int CW  = 4;
    localparam int CNT_MOD = 1 << CW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          a_valid = 1'b0;
    logic [DW-1:0] a_data = '0;
    logic          a_ready_o;
    logic          b_valid = 1'b0;
    logic [DW-1:0] b_data = '0;
    logic          b_ready_o;
    logic          y_valid_o;
    logic [DW-1:0] y_data_o;
    logic          y_src_o;
    logic          y_ready = 1'b0;
    logic          sel_o;
    logic [CW-1:0] a_cnt_o;
    logic [CW-1:0] b_cnt_o;

    mux_arbiter #(
        .DATA_W (DW),
        .CNT_W  (CW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .a_valid_i (a_valid),
        .a_data_i  (a_data),
        .a_ready_o (a_ready_o),
        .b_valid_i (b_valid),
        .b_data_i  (b_data),
        .b_ready_o (b_ready_o),
        .y_valid_o (y_valid_o),
        .y_data_o  (y_data_o),
        .y_src_o   (y_src_o),
        .y_ready_i (y_ready),
        .sel_o     (sel_o),
        .a_cnt_o   (a_cnt_o),
        .b_cnt_o   (b_cnt_o)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model state ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [DW:0] exp_q[$];          // {src, data} words expected in the output register
    int          m_last   = 1;      // source granted most recently (A wins first tie)
    int          m_cnt_a  = 0;
    int          m_cnt_b  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        reset_n = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        y_ready = 1'b0;
        exp_q.delete();
        m_last  = 1;
        m_cnt_a = 0;
        m_cnt_b = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // One cycle: drive inputs, predict arbitration, check readies/sel, then
    // record what the output register will hold after the edge.
    task automatic step(input logic av, input logic [DW-1:0] ad,
                        input logic bv, input logic [DW-1:0] bd,
                        input logic yr,
                        output logic a_acc, output logic b_acc);
        int   win;
        logic room;
        a_valid = av;
        a_data  = ad;
        b_valid = bv;
        b_data  = bd;
        y_ready = yr;
        room = (exp_q.size() == 0) || yr;
        if (av && bv) begin
`ifdef MUX_ARBITER_RR_EN
            win = 1 - m_last;
`else
            win = 0;
`endif
        end else if (av) begin
            win = 0;
        end else if (bv) begin
            win = 1;
        end else begin
            win = m_last;
        end
        a_acc = room && av && (win == 0);
        b_acc = room && bv && (win == 1);
        #2;
        chk("a_ready", a_ready_o, a_acc);
        chk("b_ready", b_ready_o, b_acc);
        chk("sel", sel_o, (win == 1));
        @(posedge clk);
        if (a_acc) begin
            exp_q.push_back({1'b0, ad});
            m_cnt_a = (m_cnt_a + 1) % CNT_MOD;
            m_last  = 0;
        end
        if (b_acc) begin
            exp_q.push_back({1'b1, bd});
            m_cnt_b = (m_cnt_b + 1) % CNT_MOD;
            m_last  = 1;
        end
        #1;
        chk("a_cnt", a_cnt_o, m_cnt_a);
        chk("b_cnt", b_cnt_o, m_cnt_b);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            @(negedge clk);
            chk("y_valid", y_valid_o, (exp_q.size() != 0));
            if (y_valid_o && exp_q.size() != 0) begin
                chk("y_data", y_data_o, exp_q[0][DW-1:0]);
                chk("y_src", y_src_o, exp_q[0][DW]);
                if (y_ready) void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    logic          aa, ba;
    logic          pa, pb;
    logic [DW-1:0] da, db;
    logic [DW-1:0] seq_a [3];

    initial begin
        // Reset then idle
        do_reset();
        chk("rst_y_valid", y_valid_o, 0);
        chk("rst_y_data", y_data_o, 0);
        chk("rst_y_src", y_src_o, 0);
        chk("rst_a_cnt", a_cnt_o, 0);
        chk("rst_b_cnt", b_cnt_o, 0);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, aa, ba);   // sel must idle at 1

        // A only, back-to-back, sink always ready
        seq_a[0] = 8'h11;
        seq_a[1] = 8'h22;
        seq_a[2] = 8'h33;
        for (int i = 0; i < 3; i++) step(1'b1, seq_a[i], 1'b0, 8'h00, 1'b1, aa, ba);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, aa, ba);
        chk("a_only_cnt", a_cnt_o, 3);

        // Both valid for 4 cycles
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 8'hAA, 1'b1, 8'hBB, 1'b1, aa, ba);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, aa, ba);
`ifdef MUX_ARBITER_RR_EN
        chk("tie_b_cnt", b_cnt_o, 2);
`else
        chk("tie_b_cnt", b_cnt_o, 0);
`endif

        // Sink stall holding 0x55, then pop and reload in the same cycle
        do_reset();
        step(1'b1, 8'h55, 1'b0, 8'h00, 1'b1, aa, ba);
        for (int i = 0; i < 3; i++) step(1'b1, 8'h66, 1'b0, 8'h00, 1'b0, aa, ba);
        chk("stall_a_cnt", a_cnt_o, 1);
        step(1'b1, 8'h66, 1'b0, 8'h00, 1'b1, aa, ba);
        chk("reload_accept", aa, 1);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, aa, ba);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, aa, ba);

        // Reset mid-stream with a word held and a_cnt = 5
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 8'h00, 1'b1, aa, ba);
        chk("pre_rst_valid", y_valid_o, 1);
        chk("pre_rst_a_cnt", a_cnt_o, 5);
        a_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid", y_valid_o, 0);
        chk("async_rst_a_cnt", a_cnt_o, 0);
        exp_q.delete();
        m_last  = 1;
        m_cnt_a = 0;
        m_cnt_b = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Counter wrap: 17 B transfers with a 4-bit counter
        for (int i = 0; i < 17; i++) step(1'b0, 8'h00, 1'b1, 8'(i * 7), 1'b1, aa, ba);
        chk("wrap_b_cnt", b_cnt_o, 1);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, aa, ba);

        // Randomized traffic with sources honouring the hold-until-ready rule
        pa = 1'b0;
        pb = 1'b0;
        da = '0;
        db = '0;
        for (int i = 0; i < 400; i++) begin
            if (!pa) begin
                pa = ($urandom_range(0, 1) == 1);
                da = 8'($urandom_range(0, 255));
            end
            if (!pb) begin
                pb = ($urandom_range(0, 1) == 1);
                db = 8'($urandom_range(0, 255));
            end
            step(pa, da, pb, db, ($urandom_range(0, 3) != 0), aa, ba);
            if (aa) pa = 1'b0;
            if (ba) pb = 1'b0;
        end

        // Drain
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, aa, ba);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, aa, ba);
        @(negedge clk);
        #1;
        chk("drain_empty", exp_q.size(), 0);

        // ---------------- final report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mux_arbiter

// File: doc/mux_arbiter.md
# mux_arbiter

Two-requester arbiter that shares the existing 2:1 mux datapath (`day1`) between two independent valid/ready sources. Each cycle, when the output register can accept data, it picks one pending requester and drives the mux select to that requester. It captures the mux output into a one-deep output register and returns ready to the winner only. It sits in front of any single-consumer sink that needs merged traffic from two producers.

## Interface
- `DATA_W`, default 8: width of the data path and the shared mux.
- `CNT_W`, default 16: width of the per-source transfer counters.

- `clk`, input, 1: single clock, rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `a_valid_i`, input, 1: source A has data.
- `a_data_i`, input, DATA_W: source A data.
- `a_ready_o`, output, 1: source A transfer accepted this cycle.
- `b_valid_i`, input, 1: source B has data.
- `b_data_i`, input, DATA_W: source B data.
- `b_ready_o`, output, 1: source B transfer accepted this cycle.
- `y_valid_o`, output, 1: output register holds data.
- `y_data_o`, output, DATA_W: registered mux output.
- `y_src_o`, output, 1: source of `y_data_o` (0 = A, 1 = B).
- `y_ready_i`, input, 1: sink accepts `y_data_o`.
- `sel_o`, output, 1: current mux select (0 = A, 1 = B). Combinational.
- `a_cnt_o`, output, CNT_W: number of A transfers since reset.
- `b_cnt_o`, output, CNT_W: number of B transfers since reset.

## Operation
- Reset values:
  - `y_valid_o` = 0, `y_data_o` = 0, `y_src_o` = 0.
  - `a_cnt_o` = 0, `b_cnt_o` = 0.
  - Last-grant pointer `last` = 1, so that A wins the first tie.
- `can_load` = `~y_valid_o | y_ready_i`.
- Winner:
  - Only A valid: A wins.
  - Only B valid: B wins.
  - Both valid: priority rule (see Configuration).
  - Neither valid: `sel_o` holds `last`.
- `sel_o` = winner, and feeds the mux `sel_i`. The mux `a_i`/`b_i` are wired to `a_data_i`/`b_data_i`.
- `a_ready_o` = `can_load & winner==A & a_valid_i`. `b_ready_o` is defined the same way for B.
- Never both readies high in one cycle. A loser's ready stays 0.
- On a transfer (valid & ready):
  - Next edge: `y_data_o` ← mux `y_o`, `y_src_o` ← winner, `y_valid_o` ← 1.
  - `last` ← winner.
  - That source's counter increments.
- Sink handshake: `y_ready_i & y_valid_o` with no new transfer → `y_valid_o` ← 0.
- Simultaneous sink pop and new load → `y_valid_o` stays 1 with the new data. This gives full throughput of one word per cycle.
- Counters wrap from all-ones to 0.
- Sources must hold valid/data stable until ready (AXI-style). The arbiter does not re-check this.

## Timing
- Input to `y_valid_o`: 1 cycle latency.
- Sustained throughput: 1 transfer per cycle when the sink is always ready.
- Sink stall (`y_ready_i`=0 with `y_valid_o`=1):
  - Both readies go low in the same cycle, combinationally.
  - `y_data_o`/`y_src_o` hold.
  - `last` is not updated.
- Combinational paths:
  - `y_ready_i` → `a_ready_o`/`b_ready_o`.
  - valids → `sel_o`.
  - No path from any ready back to any valid.
- Reset asserted mid-transfer: all registers go to reset values immediately. Any word held in the output register is dropped, and counters clear.

## Configuration
- Macro `MUX_ARBITER_RR_EN`:
  - Defined: round-robin. On a tie, the source not equal to `last` wins, so both valid continuously gives A,B,A,B…
  - Undefined: fixed priority. On a tie A always wins. The `last` register is still kept so that `sel_o` idles correctly.

## Structure
- Shared package `mux_arbiter_pkg` holds:
  - typedef `src_t` (enum `SRC_A`=0, `SRC_B`=1).
  - constants `DATA_W_DEF`=8 and `CNT_W_DEF`=16.
- One sub-module: the existing `day1` 2:1 mux, instantiated unmodified as the shared datapath. Arbitration, the output register and the counters live in `mux_arbiter`.

## Test plan
- Reset then idle: `reset_n`=0 for 2 cycles, then released with no valids → `y_valid_o`=0, counters 0, `sel_o`=1.
- A only, sink always ready: A sends 0x11, 0x22, 0x33 on back-to-back cycles → `y_data_o` shows 0x11, 0x22, 0x33 one cycle later each, `y_src_o`=0, `a_cnt_o`=3.
- Both valid for 4 cycles (A=0xAA, B=0xBB), sink ready:
  - With RR: outputs AA,BB,AA,BB.
  - Without RR: AA,AA,AA,AA and `b_ready_o` stays 0.
- Sink stall: with `y_valid_o`=1 holding 0x55, drop `y_ready_i` for 3 cycles → data held, both readies 0, counters unchanged. Re-raise it → the next word loads in the same cycle as the pop.
- Reset mid-stream: assert `reset_n`=0 while `y_valid_o`=1 and `a_cnt_o`=5 → next sample shows `y_valid_o`=0 and `a_cnt_o`=0 without waiting for a clock edge.
- Counter wrap: with CNT_W=4, perform 17 B transfers → `b_cnt_o`=1.
